// File: rtl/mcu90640_frame_ctrl.sv
// ============================================================================
//  Module   : mcu90640_frame_ctrl
//  Brief    : MLX90640 UART frame parser -> pixel RAM writer with checksum,
//             length check, inter-byte timeout and ambient (TA) capture.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu90640_frame_ctrl #(
  parameter int          PIX_NUM     = 768,
  parameter logic [15:0] LEN_EXP     = 16'h0602,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        pix_we,
  output logic [9:0]  pix_addr,
  output logic [15:0] pix_data,
  output logic [15:0] ta_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]      c_sync_byte = 8'h5A;
  localparam logic [15:0]     c_hdr_word  = 16'h5A5A;
  localparam logic [9:0]      c_last_pix  = 10'(PIX_NUM - 1);
  localparam logic [TO_W-1:0] c_to_last   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_HDR2 = 4'd1, S_LEN_L = 4'd2, S_LEN_H = 4'd3,
    S_PIX_L = 4'd4, S_PIX_H = 4'd5, S_TA_L = 4'd6, S_TA_H = 4'd7,
    S_CS_L  = 4'd8, S_CS_H = 4'd9
  } state_t;

  state_t          r_state, w_next;
  logic            r_rx_d;
  logic [7:0]      r_lo;
  logic [9:0]      r_pix_cnt;
  logic [15:0]     r_cs;
  logic [15:0]     r_ta_shadow;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_accept, w_timeout, w_pix_we, w_done, w_err;
  logic [1:0]      w_code;
  logic [15:0]     w_word;

  assign w_accept = rx_done & ~r_rx_d;
  assign w_word   = {rx_data, r_lo};
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_next    = r_state;
    w_pix_we  = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_code    = 2'b00;
    w_timeout = (r_state != S_IDLE) && (r_to_cnt == c_to_last);
    if (w_accept) begin
      case (r_state)
        S_IDLE:  if (rx_data == c_sync_byte) w_next = S_HDR2;
        S_HDR2:  w_next = (rx_data == c_sync_byte) ? S_LEN_L : S_IDLE;
        S_LEN_L: w_next = S_LEN_H;
        S_LEN_H: begin
          if (w_word == LEN_EXP) begin
            w_next = S_PIX_L;
          end else begin
            w_err  = 1'b1;
            w_code = 2'b01;
            w_next = S_IDLE;
          end
        end
        S_PIX_L: w_next = S_PIX_H;
        S_PIX_H: begin
          w_pix_we = 1'b1;
          w_next   = (r_pix_cnt == c_last_pix) ? S_TA_L : S_PIX_L;
        end
        S_TA_L:  w_next = S_TA_H;
        S_TA_H:  w_next = S_CS_L;
        S_CS_L:  w_next = S_CS_H;
        S_CS_H: begin
          w_next = S_IDLE;
          // Accumulator starts from zero, so the two header bytes are added here.
          if (w_word == r_cs + c_hdr_word) begin
            w_done = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = 2'b10;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_err  = 1'b1;
      w_code = 2'b11;
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rx_d      <= 1'b0;
      r_lo        <= 8'h00;
      r_pix_cnt   <= 10'd0;
      r_cs        <= 16'h0000;
      r_ta_shadow <= 16'h0000;
      r_to_cnt    <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= 10'd0;
      pix_data    <= 16'h0000;
      ta_data     <= 16'h0000;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_rx_d     <= rx_done;
      pix_we     <= w_pix_we;
      frame_done <= w_done;
      frame_err  <= w_err;
      if (w_done || w_err) err_code <= w_code;
      if (w_done) ta_data <= r_ta_shadow;
      if (w_pix_we) begin
        pix_addr <= r_pix_cnt;
        pix_data <= w_word;
      end

      if (w_accept || r_state == S_IDLE) r_to_cnt <= '0;
      else if (r_to_cnt != c_to_last)    r_to_cnt <= r_to_cnt + 1'b1;

      if (w_accept) begin
        r_lo <= rx_data;
        case (r_state)
          S_HDR2: if (rx_data == c_sync_byte) begin
            r_cs      <= 16'h0000;
            r_pix_cnt <= 10'd0;
          end
          S_LEN_H: r_cs <= r_cs + w_word;
          S_PIX_H: begin
            r_cs      <= r_cs + w_word;
            r_pix_cnt <= (r_pix_cnt == c_last_pix) ? 10'd0 : r_pix_cnt + 10'd1;
          end
          S_TA_H: begin
            r_cs        <= r_cs + w_word;
            r_ta_shadow <= w_word;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mcu90640_frame_ctrl.md
MCU90640_FRAME_CTRL -- requirements
Module: mcu90640_frame_ctrl

Interface
REQ-001 SHALL have parameter PIX_NUM, default 768: pixel words per frame.
REQ-002 SHALL have parameter LEN_EXP, default 16'h0602: expected length word.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000: inter-byte timeout in clk_50m cycles (1 ms).
REQ-004 SHALL have port clk_50m  input  1  system clock (clock clk_50m).
REQ-005 SHALL have port rst_n  input  1  reset rst_n, asynchronous, active-low.
REQ-006 SHALL have port rx_done  input  1  UART byte-complete flag; level, may stay high for many cycles.
REQ-007 SHALL have port rx_data  input  8  received byte; valid while rx_done high.
REQ-008 SHALL have port pix_we  output  1  one-cycle pixel RAM write strobe.
REQ-009 SHALL have port pix_addr  output  10  pixel index 0..PIX_NUM-1.
REQ-010 SHALL have port pix_data  output  16  pixel word, {high byte, low byte}.
REQ-011 SHALL have port ta_data  output  16  ambient word of last good frame.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse, good frame.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse, aborted frame.
REQ-014 SHALL have port err_code  output  2  01 length, 10 checksum, 11 timeout; holds until next frame_done/frame_err.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL accept a byte only in the cycle where rx_done=1 and registered rx_done=0 (rising edge); exactly one acceptance per rx_done high period.
REQ-017 SHALL use states IDLE, HDR2, LEN_L, LEN_H, PIX_L, PIX_H, TA_L, TA_H, CS_L, CS_H; every transition occurs only on an accepted byte, except timeout.
REQ-018 IDLE: byte 0x5A -> HDR2; any other byte -> stay IDLE, no error.
REQ-019 HDR2: 0x5A -> LEN_L; other byte -> IDLE, no error.
REQ-020 LEN_L -> LEN_H; LEN_H: {byte, LEN_L byte} == LEN_EXP -> PIX_L, else frame_err, err_code=01, -> IDLE.
REQ-021 PIX_L latches low byte -> PIX_H; PIX_H: the following cycle pix_we=1, pix_addr=pixel counter, pix_data={byte, low}; counter increments.
REQ-022 After write of pix_addr=PIX_NUM-1 SHALL go to TA_L and clear the pixel counter to 0 (no wrap past PIX_NUM-1).
REQ-023 TA_L -> TA_H -> CS_L; TA word held in a shadow register, not in ta_data.
REQ-024 Checksum SHALL be the 16-bit modulo sum of 0x5A5A, length word, all pixel words and TA word; carries discarded.
REQ-025 CS_H: the following cycle, if {byte, CS_L byte} equals checksum, frame_done=1 and ta_data=shadow; else frame_err=1, err_code=10, ta_data unchanged; -> IDLE in both cases.
REQ-026 Pixel writes already issued in a failed frame SHALL NOT be retracted.
REQ-027 Timeout counter SHALL clear on every accepted byte and in IDLE; on reaching TIMEOUT_CYC-1 outside IDLE: frame_err=1, err_code=11, -> IDLE.
REQ-028 Accepted byte and timeout expiry in the same cycle: byte wins, no timeout.
REQ-029 At most one of pix_we, frame_done, frame_err SHALL be high in any cycle; each high exactly one cycle.
REQ-030 Checksum accumulator and pixel counter SHALL clear on entry to LEN_L.

Reset
REQ-031 rst_n low SHALL immediately force IDLE; pix_we, frame_done, frame_err, busy=0; pix_addr, pix_data, ta_data=0; err_code=00; all counters and the rx_done edge register=0.
REQ-032 Reset mid-frame SHALL discard the partial frame without a frame_err pulse; first byte after release is handled from IDLE.

Verification
REQ-033 Good frame: 5A 5A 02 06, pixels k=0..767 as word k, TA 0x1234, correct checksum -> 768 pix_we with pix_addr=pix_data=k, one frame_done, ta_data=0x1234.
REQ-034 Corrupted checksum (correct value +1) -> frame_err, err_code=10, ta_data keeps prior 0x1234, 768 writes observed.
REQ-035 Length bytes 00 06 -> frame_err, err_code=01 one cycle after 2nd length byte, no pix_we.
REQ-036 Stop after pixel 100 -> frame_err, err_code=11, TIMEOUT_CYC cycles after last byte; following good frame completes with frame_done.
REQ-037 rx_done held high 217 cycles per byte, plus garbage bytes 00 5A 11 before the header -> one acceptance per byte, frame still decodes correctly.
REQ-038 rst_n pulsed low at pixel 400 -> outputs at reset values, no frame_err; next good frame gives frame_done.
